// File: rtl/duty_ramp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | duty_ramp : slews a PWM duty (permille) toward an accepted target.        |
// | Optional brake input enabled by macro DUTY_RAMP_BRAKE_EN.    Rev 1.0      |
// +--------------------------------------------------------------------------+
module duty_ramp #(
  parameter int SYS_CLK  = 24_000_000,
  parameter int RAMP_HZ  = 1000,
  parameter int STEP     = 10,
  parameter int DUTY_MAX = 1000
) (
  input  logic        clk_24M,
  input  logic        rst,
`ifdef DUTY_RAMP_BRAKE_EN
  input  logic        brake,
`endif
  input  logic        tgt_valid,
  output logic        tgt_ready,
  input  logic [10:0] tgt_duty,
  input  logic        tgt_dir,
  output logic [10:0] perctg,
  output logic        dir,
  output logic        at_target
);

  localparam int PRESC_N = SYS_CLK / RAMP_HZ;
  localparam int PW      = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
  localparam logic [PW-1:0] C_TERM     = PW'(PRESC_N - 1);
  localparam logic [10:0]   C_STEP     = 11'(STEP);
  localparam logic [11:0]   C_STEP12   = 12'(STEP);
  localparam logic [10:0]   C_DUTY_MAX = 11'(DUTY_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_UP      = 2'd1,
    S_DOWN    = 2'd2,
    S_REVERSE = 2'd3
  } state_t;

  state_t      r_state, w_state_n;
  logic [PW-1:0] r_presc;
  logic        w_tick;
  logic [10:0] r_perctg, w_perctg_n;
  logic [10:0] r_target;
  logic        r_tgt_dir;
  logic        r_dir, w_dir_n;
  logic        r_eval;
  logic        w_accept;
  logic [10:0] w_clamped;
  logic [11:0] w_up_sum, w_dn_floor;
  logic [10:0] w_up_val, w_dn_val, w_rev_val;

  assign w_tick    = (r_presc == C_TERM);
`ifdef DUTY_RAMP_BRAKE_EN
  assign tgt_ready = (r_state != S_REVERSE) && !brake;
`else
  assign tgt_ready = (r_state != S_REVERSE);
`endif
  assign w_accept  = tgt_valid && tgt_ready;
  assign w_clamped = (tgt_duty > C_DUTY_MAX) ? C_DUTY_MAX : tgt_duty;

  // Step arithmetic done 12 bits wide so neither direction can wrap.
  assign w_up_sum   = {1'b0, r_perctg} + C_STEP12;
  assign w_up_val   = (w_up_sum < {1'b0, r_target}) ? w_up_sum[10:0] : r_target;
  assign w_dn_floor = {1'b0, r_target} + C_STEP12;
  assign w_dn_val   = ({1'b0, r_perctg} > w_dn_floor) ? (r_perctg - C_STEP) : r_target;
  assign w_rev_val  = (r_perctg > C_STEP) ? (r_perctg - C_STEP) : 11'd0;

  assign perctg    = r_perctg;
  assign dir       = r_dir;
  assign at_target = (r_state == S_IDLE) && (r_perctg == r_target) && (r_dir == r_tgt_dir);

  always_ff @(posedge clk_24M) begin
    if (rst) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_tick ? '0 : (r_presc + PW'(1));
    end
  end

  // A freshly accepted target is judged on the following cycle; no ramp step
  // is applied during that evaluation cycle.
  always_comb begin
    w_state_n  = r_state;
    w_perctg_n = r_perctg;
    w_dir_n    = r_dir;
    if (r_eval) begin
      if (r_dir != r_tgt_dir) begin
        if (r_perctg != 11'd0) begin
          w_state_n = S_REVERSE;
        end else begin
          w_dir_n   = ~r_dir;
          w_state_n = (r_target == 11'd0) ? S_IDLE : S_UP;
        end
      end else if (r_target > r_perctg) begin
        w_state_n = S_UP;
      end else if (r_target < r_perctg) begin
        w_state_n = S_DOWN;
      end else begin
        w_state_n = S_IDLE;
      end
    end else begin
      case (r_state)
        S_UP: begin
          if (w_tick) begin
            w_perctg_n = w_up_val;
            if (w_up_val == r_target) w_state_n = S_IDLE;
          end
        end
        S_DOWN: begin
          if (w_tick) begin
            w_perctg_n = w_dn_val;
            if (w_dn_val == r_target) w_state_n = S_IDLE;
          end
        end
        S_REVERSE: begin
          if (r_perctg == 11'd0) begin
            w_dir_n   = ~r_dir;
            w_state_n = (r_target == 11'd0) ? S_IDLE : S_UP;
          end else if (w_tick) begin
            w_perctg_n = w_rev_val;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_24M) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_perctg  <= 11'd0;
      r_dir     <= 1'b1;
      r_target  <= 11'd0;
      r_tgt_dir <= 1'b1;
      r_eval    <= 1'b0;
    end else
`ifdef DUTY_RAMP_BRAKE_EN
    if (brake) begin
      r_state   <= S_IDLE;
      r_perctg  <= 11'd0;
      r_target  <= 11'd0;
      r_tgt_dir <= r_dir;
      r_eval    <= 1'b0;
    end else
`endif
    begin
      r_state  <= w_state_n;
      r_perctg <= w_perctg_n;
      r_dir    <= w_dir_n;
      r_eval   <= w_accept;
      if (w_accept) begin
        r_target  <= w_clamped;
        r_tgt_dir <= tgt_dir;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_duty_ramp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_duty_ramp : directed self-checking bench for duty_ramp (tick = 10 clk).|
// | Brake scenario built when DUTY_RAMP_BRAKE_EN is defined.     Rev 1.0      |
// +--------------------------------------------------------------------------+
module tb_duty_ramp;

  logic        clk_24M = 1'b0;
  logic        rst = 1'b1;
  logic        tgt_valid = 1'b0;
  logic        tgt_ready;
  logic [10:0] tgt_duty = '0;
  logic        tgt_dir = 1'b1;
  logic [10:0] perctg;
  logic        dir;
  logic        at_target;
`ifdef DUTY_RAMP_BRAKE_EN
  logic        brake = 1'b0;
`endif

  duty_ramp #(
    .SYS_CLK (10),
    .RAMP_HZ (1),
    .STEP    (10),
    .DUTY_MAX(1000)
  ) dut (
    .clk_24M  (clk_24M),
    .rst      (rst),
`ifdef DUTY_RAMP_BRAKE_EN
    .brake    (brake),
`endif
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .tgt_duty (tgt_duty),
    .tgt_dir  (tgt_dir),
    .perctg   (perctg),
    .dir      (dir),
    .at_target(at_target)
  );

  always #5 clk_24M = ~clk_24M;

  // Reference prescaler: the tick edge is the one where pc is 9 beforehand.
  int pc = 0;
  always @(posedge clk_24M) begin
    if (rst) pc <= 0;
    else     pc <= (pc == 9) ? 0 : pc + 1;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_24M);
    rst = 1'b0;
  endtask

  task automatic align();
    int g = 0;
    while (pc != 0 && g < 20) begin @(negedge clk_24M); g++; end
  endtask

  task automatic to_tick();
    int g = 0;
    while (pc != 9 && g < 20) begin @(negedge clk_24M); g++; end
    @(negedge clk_24M);
  endtask

  task automatic accept(input int d, input bit dr);
    align();
    chk("ready_before_accept", int'(tgt_ready), 1);
    tgt_duty  = 11'(d);
    tgt_dir   = dr;
    tgt_valid = 1'b1;
    @(negedge clk_24M);
    tgt_valid = 1'b0;
  endtask

  typedef struct {
    int duty;
    bit tdir;
    int ticks;
    int exp_p;
    bit exp_d;
    bit exp_at;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int maxp;
    vecs[0] = '{100,  1'b1, 10,  100,  1'b1, 1'b1};
    vecs[1] = '{40,   1'b1, 6,   40,   1'b1, 1'b1};
    vecs[2] = '{40,   1'b1, 0,   40,   1'b1, 1'b1};
    vecs[3] = '{2000, 1'b1, 97,  1000, 1'b1, 1'b1};
    vecs[4] = '{0,    1'b0, 101, 0,    1'b0, 1'b1};
    vecs[5] = '{15,   1'b0, 2,   15,   1'b0, 1'b1};
    vecs[6] = '{5,    1'b0, 1,   5,    1'b0, 1'b1};
    vecs[7] = '{0,    1'b1, 2,   0,    1'b1, 1'b1};

    do_reset();
    @(negedge clk_24M);
    chk("reset_perctg", int'(perctg), 0);
    chk("reset_dir", int'(dir), 1);
    chk("reset_at_target", int'(at_target), 1);
    chk("reset_ready", int'(tgt_ready), 1);

    // Table: rows applied back to back, each starting from the previous result.
    for (int i = 0; i < 8; i++) begin
      accept(vecs[i].duty, vecs[i].tdir);
      for (int t = 0; t < vecs[i].ticks; t++) to_tick();
      chk($sformatf("vec%0d_perctg", i), int'(perctg), vecs[i].exp_p);
      chk($sformatf("vec%0d_dir", i), int'(dir), int'(vecs[i].exp_d));
      chk($sformatf("vec%0d_at_target", i), int'(at_target), int'(vecs[i].exp_at));
    end

    // Plain ramp 0 -> 100 one step per tick.
    do_reset();
    accept(100, 1'b1);
    chk("ramp_at_target_early", int'(at_target), 0);
    for (int k = 1; k <= 10; k++) begin
      to_tick();
      chk($sformatf("ramp_tick%0d", k), int'(perctg), 10 * k);
      chk($sformatf("ramp_at_tick%0d", k), int'(at_target), (k == 10) ? 1 : 0);
    end

    // Partial last step, then clamp above full scale.
    do_reset();
    accept(25, 1'b1);
    to_tick(); chk("clamp_p1", int'(perctg), 10);
    to_tick(); chk("clamp_p2", int'(perctg), 20);
    to_tick(); chk("clamp_p3", int'(perctg), 25);
    accept(1500, 1'b1);
    maxp = 0;
    for (int k = 0; k < 103; k++) begin
      to_tick();
      if (int'(perctg) > maxp) maxp = int'(perctg);
    end
    chk("clamp_max_seen", maxp, 1000);
    chk("clamp_hold", int'(perctg), 1000);
    chk("clamp_at_target", int'(at_target), 1);

    // Direction reversal through zero.
    do_reset();
    accept(50, 1'b1);
    repeat (5) to_tick();
    chk("rev_start", int'(perctg), 50);
    accept(30, 1'b0);
    @(negedge clk_24M);
    chk("rev_ready_low", int'(tgt_ready), 0);
    for (int k = 1; k <= 5; k++) begin
      to_tick();
      chk($sformatf("rev_down%0d", k), int'(perctg), 50 - 10 * k);
    end
    chk("rev_dir_before_flip", int'(dir), 1);
    @(negedge clk_24M);
    chk("rev_dir_flipped", int'(dir), 0);
    chk("rev_ready_high", int'(tgt_ready), 1);
    for (int k = 1; k <= 3; k++) begin
      to_tick();
      chk($sformatf("rev_up%0d", k), int'(perctg), 10 * k);
    end
    chk("rev_at_target", int'(at_target), 1);

    // Latest target wins mid-ramp.
    do_reset();
    accept(100, 1'b1);
    repeat (6) to_tick();
    chk("retarget_start", int'(perctg), 60);
    accept(20, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      to_tick();
      chk($sformatf("retarget_down%0d", k), int'(perctg), 60 - 10 * k);
    end
    chk("retarget_at_target", int'(at_target), 1);

    // Reset mid-ramp.
    do_reset();
    accept(100, 1'b1);
    repeat (7) to_tick();
    chk("rst_start", int'(perctg), 70);
    rst = 1'b1;
    @(negedge clk_24M);
    chk("rst_perctg", int'(perctg), 0);
    chk("rst_dir", int'(dir), 1);
    chk("rst_at_target", int'(at_target), 1);
    rst = 1'b0;
    repeat (2) to_tick();
    chk("rst_no_change", int'(perctg), 0);

`ifdef DUTY_RAMP_BRAKE_EN
    do_reset();
    accept(100, 1'b1);
    repeat (8) to_tick();
    chk("brake_start", int'(perctg), 80);
    brake = 1'b1;
    @(negedge clk_24M);
    chk("brake_perctg", int'(perctg), 0);
    chk("brake_ready", int'(tgt_ready), 0);
    tgt_duty  = 11'd500;
    tgt_valid = 1'b1;
    repeat (2) to_tick();
    chk("brake_hold", int'(perctg), 0);
    tgt_valid = 1'b0;
    brake     = 1'b0;
    repeat (2) to_tick();
    chk("brake_released", int'(perctg), 0);
    chk("brake_at_target", int'(at_target), 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/duty_ramp.md
DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 SHALL have parameter SYS_CLK, default 24_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter RAMP_HZ, default 1000, ramp step rate in Hz.
REQ-003 SHALL have parameter STEP, default 10, duty increment per ramp tick, in permille.
REQ-004 SHALL have parameter DUTY_MAX, default 1000, full-scale duty in permille.
REQ-005 SHALL have port clk_24M, input, 1 bit, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port tgt_valid, input, 1 bit, new target offered.
REQ-008 SHALL have port tgt_ready, output, 1 bit, target can be accepted this cycle.
REQ-009 SHALL have port tgt_duty, input, 11 bits, requested duty in permille.
REQ-010 SHALL have port tgt_dir, input, 1 bit, requested direction (1 = forward).
REQ-011 SHALL have port perctg, output, 11 bits, current duty in permille; drives the downstream PWM generator duty input.
REQ-012 SHALL have port dir, output, 1 bit, current motor direction.
REQ-013 SHALL have port at_target, output, 1 bit, high when perctg equals the accepted target and dir equals the accepted direction.

Function
REQ-014 SHALL run a free-running prescaler from 0 to SYS_CLK/RAMP_HZ-1 that pulses an internal tick for one cycle at terminal count and then wraps to 0; accepting a new target SHALL NOT restart the prescaler.
REQ-015 SHALL accept a target on any cycle where tgt_valid and tgt_ready are both high, and SHALL register the clamped target and tgt_dir at that clock edge.
REQ-016 SHALL clamp any tgt_duty above DUTY_MAX to DUTY_MAX on acceptance.
REQ-017 SHALL implement the states IDLE, UP, DOWN and REVERSE; tgt_ready SHALL be high in every state except REVERSE.
REQ-018 SHALL, on the cycle after acceptance, choose the next state as follows:
- dir differs and perctg is nonzero: REVERSE.
- dir differs and perctg is 0: flip dir, then go to UP, or to IDLE if the target is 0.
- same dir, target above perctg: UP.
- same dir, target below perctg: DOWN.
- same dir, target equal: IDLE.
REQ-019 SHALL, in UP on a tick, set perctg to min(perctg+STEP, target), then go to IDLE when the target is reached.
REQ-020 SHALL, in DOWN on a tick, set perctg to max(perctg-STEP, target) without underflow, then go to IDLE when the target is reached.
REQ-021 SHALL, in REVERSE on a tick, set perctg to max(perctg-STEP, 0); on the cycle after perctg reaches 0 it SHALL flip dir and go to UP, or to IDLE if the target is 0.
REQ-022 SHALL let a target accepted in UP or DOWN replace the previous target, with the state re-evaluated per REQ-018 on the next cycle (latest wins).
REQ-023 SHALL change perctg only on tick cycles, and SHALL never drive perctg above DUTY_MAX.
REQ-024 SHALL drive at_target high only in IDLE.

Reset
REQ-025 SHALL, while rst is high at a clock edge, set perctg=0, dir=1, target=0, accepted direction=1, prescaler=0, state=IDLE, tgt_ready=1 and at_target=1.
REQ-026 SHALL let rst abort any ramp or REVERSE immediately, with no further ticks applied.

Configuration
REQ-027 SHALL, when macro DUTY_RAMP_BRAKE_EN is defined, add input port brake (1 bit). While brake is high: perctg is forced to 0 on the next edge, the state goes to IDLE, the target is set to 0, and tgt_ready is held low. After brake is released, normal operation resumes and a new target is required.
REQ-028 SHALL, when DUTY_RAMP_BRAKE_EN is undefined, have no brake port and no brake logic.

Verification (RAMP_HZ overridden so the tick period is 10 cycles, STEP=10)
REQ-029 SHALL show: from reset, accept 100 forward -> perctg steps 10,20,...,100 on successive ticks; at_target rises after the 10th tick.
REQ-030 SHALL show: at 0, accept 25 -> perctg 10, 20, 25; then accept 1500 -> ramps to 1000 and holds, never exceeding 1000.
REQ-031 SHALL show: at 50 forward, accept 30 reverse -> tgt_ready goes low; perctg 40..0 over 5 ticks; dir goes to 0; tgt_ready returns high; perctg 10, 20, 30.
REQ-032 SHALL show: ramping up toward 100 at perctg 60, accept 20 forward -> DOWN; perctg 50, 40, 30, 20.
REQ-033 SHALL show: rst asserted at perctg 70 mid-ramp -> next edge perctg=0, dir=1, at_target=1, and no further change.
REQ-034 SHALL show (DUTY_RAMP_BRAKE_EN defined): brake asserted at perctg 80 -> perctg=0 on the next edge; tgt_valid ignored while brake is high.
